// File: rtl/seqdet_pkg.sv
// Shared state encoding and default widths for the stream-fed sequence detector.
package seqdet_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/seqdet_pattern_match.sv
// Moore-style matcher: slides each valid bit into a history window and
// raises a registered one-cycle det once the full window equals the pattern.
module seqdet_pattern_match #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  output logic             det_o
);

  localparam int                SEEN_W    = $clog2(PAT_W + 1);
  localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [SEEN_W-1:0] seen_q, seen_d;
  logic              det_q, det_d;

  // seen-count keeps a partially filled window from matching a zero pattern
  always_comb begin
    hist_d = hist_q;
    seen_d = seen_q;
    det_d  = 1'b0;
    if (clr_i) begin
      hist_d = '0;
      seen_d = '0;
    end else if (bit_valid_i) begin
      hist_d = {hist_q[PAT_W-2:0], bit_i};
      if (seen_q != SEEN_FULL) seen_d = seen_q + 1'b1;
      det_d = (seen_d == SEEN_FULL) && (hist_d == pattern_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      seen_q <= '0;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      seen_q <= seen_d;
      det_q  <= det_d;
    end
  end

  assign det_o = det_q;

endmodule

// File: rtl/seqdet_stream_ctrl.sv
// Word-to-bit stream scheduler and config front-end for the pattern matcher,
// with a saturating detection counter and sticky threshold interrupt.
module seqdet_stream_ctrl
  import seqdet_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              det,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              irq,
  input  logic              irq_clr,
  output logic              busy
);

  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;
  logic               cfg_take;
  logic               det_w;

  assign cfg_take = cfg_we && (state_q == IDLE);

  // Ready is also offered on the final bit so consecutive words stream gaplessly
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          shreg_d = in_data;
          idx_d   = IDX_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bit_valid = 1'b1;
        shreg_d   = shreg_q << 1;
        idx_d     = idx_q - 1'b1;
        if (idx_q == '0) begin
          in_ready = rst_n;
          if (in_valid && rst_n) begin
            shreg_d = in_data;
            idx_d   = IDX_LAST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // irq fires only on the transition into the threshold, so a pending set beats a clear
  always_comb begin
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    cnt_d     = cnt_q;
    irq_d     = irq_q;
    if (cfg_take) begin
      pattern_d = cfg_pattern;
      thresh_d  = cfg_thresh;
      cnt_d     = '0;
      irq_d     = 1'b0;
    end else begin
      if (det_w && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      if ((cnt_d != cnt_q) && (cnt_d == thresh_q) && (thresh_q != '0)) begin
        irq_d = 1'b1;
      end else if (irq_clr) begin
        irq_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      pattern_q <= '0;
      thresh_q  <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      pattern_q <= pattern_d;
      thresh_q  <= thresh_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
    end
  end

  seqdet_pattern_match #(
    .PAT_W(PAT_W)
  ) u_match (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cfg_take),
    .pattern_i  (pattern_q),
    .bit_valid_i(bit_valid),
    .bit_i      (bit_out),
    .det_o      (det_w)
  );

  assign bit_out   = bit_valid & shreg_q[DATA_W-1];
  assign det       = det_w;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_seqdet_stream_ctrl.sv
// Scoreboard bench: the driver queues expected bits/detects per accepted word
// and a negedge monitor pops and compares them as the stream comes out.
module tb_seqdet_stream_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       cfgWe;
  logic [3:0] cfgPattern;
  logic [7:0] cfgThresh;
  logic       inValid;
  logic [7:0] inData;
  logic       inReady;
  logic       bitOut;
  logic       bitValid;
  logic       det;
  logic [7:0] matchCnt;
  logic       irq;
  logic       irqClr;
  logic       busy;

  logic       sCfgWe;
  logic [1:0] sCfgPattern;
  logic [1:0] sCfgThresh;
  logic       sInValid;
  logic [7:0] sInData;
  logic       sInReady;
  logic       sBitOut;
  logic       sBitValid;
  logic       sDet;
  logic [1:0] sMatchCnt;
  logic       sIrq;
  logic       sIrqClr;
  logic       sBusy;

  int checkCount = 0;
  int passCount  = 0;
  int gapCount   = 0;
  int detSeen    = 0;
  int watchN     = 0;
  int satDets    = 0;
  int satBits    = 0;
  int detBefore  = 0;

  logic [1:0] bitQ[$];
  logic       detQ[$];
  logic [3:0] mHist;
  logic [3:0] mPat;
  int         mSeen;
  logic       prevBitValid = 1'b0;
  logic       prevRstN     = 1'b0;

  always #5 clk = ~clk;

  seqdet_stream_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rstN), .cfg_we(cfgWe), .cfg_pattern(cfgPattern),
    .cfg_thresh(cfgThresh), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady), .bit_out(bitOut), .bit_valid(bitValid), .det(det),
    .match_cnt(matchCnt), .irq(irq), .irq_clr(irqClr), .busy(busy)
  );

  seqdet_stream_ctrl #(.DATA_W(8), .PAT_W(2), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rstN), .cfg_we(sCfgWe), .cfg_pattern(sCfgPattern),
    .cfg_thresh(sCfgThresh), .in_valid(sInValid), .in_data(sInData),
    .in_ready(sInReady), .bit_out(sBitOut), .bit_valid(sBitValid), .det(sDet),
    .match_cnt(sMatchCnt), .irq(sIrq), .irq_clr(sIrqClr), .busy(sBusy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic pushWord(input logic [7:0] w);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      b = w[i];
      bitQ.push_back({(i == 0), b});
      mHist = {mHist[2:0], b};
      if (mSeen < 4) mSeen++;
      detQ.push_back((mSeen == 4) && (mHist == mPat));
    end
  endtask

  task automatic configure(input logic [3:0] pat, input logic [7:0] thr);
    cfgWe = 1'b1;
    cfgPattern = pat;
    cfgThresh = thr;
    @(posedge clk); #2;
    cfgWe = 1'b0;
    mPat = pat;
    mHist = '0;
    mSeen = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1, input int nWords);
    int n;
    logic [7:0] w;
    for (int k = 0; k < nWords; k++) begin
      w = (k == 0) ? w0 : w1;
      inValid = 1'b1;
      inData = w;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (k > 0 && !bitValid) gapCount++;
      end while (!inReady && n < 40);
      if (!inReady) begin
        checkCount++;
        $display("[TB] FAIL acceptTimeout: in_ready low for %0d cycles, required high", n);
        inValid = 1'b0;
        return;
      end
      @(posedge clk); #2;
      pushWord(w);
      if (k == nWords - 1) inValid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || bitQ.size() != 0) && n < 60);
    if (busy || bitQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL waitIdle: busy=%0d after %0d cycles, required 0", busy, n);
    end
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
  endtask

  // det for a bit shows up the cycle after it, unless a reset edge intervened
  always @(negedge clk) begin
    logic [1:0] ent;
    logic       expDet;
    if (det) detSeen++;
    if (prevBitValid && prevRstN) begin
      if (detQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL detQueue: det=%0d with nothing expected, required queued entry", det);
      end else begin
        expDet = detQ.pop_front();
        checkOutput("det", 32'(det), 32'(expDet));
      end
    end
    if (bitValid) begin
      if (bitQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL bitQueue: bit_valid=1 with no bit expected, required 0");
      end else begin
        ent = bitQ.pop_front();
        checkOutput("bitOut", 32'(bitOut), 32'(ent[0]));
        checkOutput("inReadyLastBit", 32'(inReady), 32'(ent[1]));
      end
    end
    prevBitValid = bitValid;
    prevRstN = rstN;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit hit, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstN = 1'b0; cfgWe = 1'b0; cfgPattern = '0; cfgThresh = '0;
    inValid = 1'b1; inData = 8'hAA; irqClr = 1'b0;
    sCfgWe = 1'b0; sCfgPattern = '0; sCfgThresh = '0;
    sInValid = 1'b0; sInData = '0; sIrqClr = 1'b0;
    mHist = '0; mPat = '0; mSeen = 0;

    // reset held with a word offered: nothing may be accepted or emitted
    repeat (2) begin
      @(negedge clk);
      checkOutput("resetBitValid", 32'(bitValid), 32'd0);
      checkOutput("resetInReady", 32'(inReady), 32'd0);
    end
    @(posedge clk); #2;
    rstN = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    checkOutput("idleInReady", 32'(inReady), 32'd1);
    checkOutput("idleBitValid", 32'(bitValid), 32'd0);
    checkOutput("idleBitOut", 32'(bitOut), 32'd0);
    checkOutput("idleDet", 32'(det), 32'd0);
    checkOutput("idleMatchCnt", 32'(matchCnt), 32'd0);
    checkOutput("idleIrq", 32'(irq), 32'd0);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    @(posedge clk); #2;

    // single word B6 against 1011: hits after bits 4 and 7
    configure(4'b1011, 8'd2);
    detBefore = detSeen;
    applyStimulus(8'hB6, 8'h00, 1);
    waitIdle();
    checkOutput("b6DetCount", 32'(detSeen - detBefore), 32'd2);
    checkOutput("b6MatchCnt", 32'(matchCnt), 32'd2);
    checkOutput("b6Irq", 32'(irq), 32'd1);
    irqClr = 1'b1;
    @(posedge clk); #2;
    irqClr = 1'b0;
    checkOutput("irqCleared", 32'(irq), 32'd0);

    // gapless 0B,B0 with irq_clr held so the set collides with a clear
    configure(4'b1011, 8'd2);
    detBefore = detSeen;
    gapCount = 0;
    irqClr = 1'b1;
    fork
      applyStimulus(8'h0B, 8'hB0, 2);
      begin
        watchN = 0;
        do begin
          @(negedge clk);
          watchN++;
        end while (matchCnt != 8'd2 && watchN < 60);
        checkOutput("irqSetWinsOverClr", 32'(irq), 32'd1);
        @(negedge clk);
        checkOutput("irqClrNextCycle", 32'(irq), 32'd0);
      end
    join
    waitIdle();
    irqClr = 1'b0;
    checkOutput("b2bGaps", 32'(gapCount), 32'd0);
    checkOutput("b2bDetCount", 32'(detSeen - detBefore), 32'd2);
    checkOutput("b2bMatchCnt", 32'(matchCnt), 32'd2);

    // third hit passes the threshold again without re-firing irq
    applyStimulus(8'hB0, 8'h00, 1);
    waitIdle();
    checkOutput("noRefireCnt", 32'(matchCnt), 32'd3);
    checkOutput("noRefireIrq", 32'(irq), 32'd0);

    // config write while shifting must be ignored
    detBefore = detSeen;
    applyStimulus(8'hB6, 8'h00, 1);
    @(posedge clk); #2;
    cfgWe = 1'b1; cfgPattern = 4'b0000; cfgThresh = 8'd0;
    @(posedge clk); #2;
    cfgWe = 1'b0;
    waitIdle();
    checkOutput("cfgIgnoredDets", 32'(detSeen - detBefore), 32'd2);
    checkOutput("cfgIgnoredCnt", 32'(matchCnt), 32'd5);

    // reset in the middle of a word drops the rest of it
    applyStimulus(8'hB6, 8'h00, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rstN = 1'b0;
    @(posedge clk); #2;
    bitQ.delete();
    detQ.delete();
    mHist = '0; mPat = '0; mSeen = 0;
    @(negedge clk);
    checkOutput("midResetBitValid", 32'(bitValid), 32'd0);
    checkOutput("midResetMatchCnt", 32'(matchCnt), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rstN = 1'b1;
    @(posedge clk); #2;

    // narrow counter: eight ones against 11 give seven hits, count pins at 3
    sCfgWe = 1'b1; sCfgPattern = 2'b11; sCfgThresh = 2'd3;
    @(posedge clk); #2;
    sCfgWe = 1'b0;
    sInValid = 1'b1; sInData = 8'hFF;
    @(negedge clk);
    checkOutput("satInReady", 32'(sInReady), 32'd1);
    @(posedge clk); #2;
    sInValid = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (sDet) satDets++;
      if (sBitValid) satBits++;
    end
    checkOutput("satBits", 32'(satBits), 32'd8);
    checkOutput("satDets", 32'(satDets), 32'd7);
    checkOutput("satMatchCnt", 32'(sMatchCnt), 32'd3);
    checkOutput("satIrq", 32'(sIrq), 32'd1);

    checkOutput("bitQueueDrained", 32'(bitQ.size()), 32'd0);
    checkOutput("detQueueDrained", 32'(detQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
